// File: rtl/buks_ram_pkg.sv
// Shared types and defaults for the frame-buffer read side (ram_dual, 4096x8, two pages).
package buks_ram_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int PAGE_W = 1;

    localparam logic [DATA_W-1:0] RAM_IDLE_BYTE = 8'hE1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        CSUM,
        DONE
    } rfr_state_t;

    // len is already saturated to the page size when a request is built
    typedef struct packed {
        logic [PAGE_W-1:0]   page;
        logic [ADDR_W-PAGE_W:0] len;
    } rfr_req_t;

endpackage

// File: rtl/frame_req_slot.sv
// Single-entry holding register for frame requests that arrive while the reader is busy.
module frame_req_slot
    import buks_ram_pkg::*;
(
    input  logic                        rd_clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [$bits(rfr_req_t)-1:0] push_req,
    input  logic                        pop,
    input  logic                        ovf_clr,
    output logic [$bits(rfr_req_t)-1:0] req,
    output logic                        full,
    output logic                        ovf
);

    // NOTE: state lives in always_ff with <= only, so every flop samples the pre-edge values.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            req  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push && (pop || !full)) begin
                req  <= push_req;
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end

            // a drop in the same cycle as a clear keeps the flag set
            if (push && full && !pop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_frame_reader.sv
// Drains one frame-buffer page to a valid/ready byte stream; CHECKSUM_EN appends an XOR byte.
module ram_frame_reader #(
    parameter int ADDR_W = buks_ram_pkg::ADDR_W,
    parameter int DATA_W = buks_ram_pkg::DATA_W,
    parameter int PAGE_W = buks_ram_pkg::PAGE_W
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PAGE_W-1:0]    start_page,
    input  logic [ADDR_W-PAGE_W:0] start_len,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic                 rd,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last
);
    import buks_ram_pkg::*;

    localparam int OFF_W = ADDR_W - PAGE_W;
    localparam int LEN_W = OFF_W + 1;
    localparam logic [LEN_W-1:0] PAGE_SZ = LEN_W'(1) << OFF_W;

    rfr_state_t        state;
    logic [PAGE_W-1:0] page;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  offset;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    rfr_req_t new_req, pend_req, next_req;
    logic     pend_valid, push, take_pend, take_direct, accept;
    logic     more, can_fetch, fetch, hshake;

    assign new_req.page = start_page;
    assign new_req.len  = (start_len > PAGE_SZ) ? PAGE_SZ : start_len;

    // the slot is only bypassed when the FSM is idle and nothing is queued ahead
    assign take_pend   = pend_valid && (state == IDLE || state == DONE);
    assign take_direct = start && (state == IDLE) && !pend_valid;
    assign push        = start && !take_direct;
    assign accept      = take_pend || take_direct;
    assign next_req    = take_pend ? pend_req : new_req;

    frame_req_slot u_slot (
        .rd_clk   (rd_clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req (new_req),
        .pop      (take_pend),
        .ovf_clr  (ovf_clr),
        .req      (pend_req),
        .full     (pend_valid),
        .ovf      (ovf)
    );

    // RAM data is combinational, so the read strobe must follow this cycle's tx_ready
    assign more      = offset < len;
    assign can_fetch = !tx_valid || tx_ready;
    assign fetch     = (state == LOAD || state == SEND) && more && can_fetch;
    assign hshake    = tx_valid && tx_ready;
    assign rd        = fetch;
    assign rd_addr   = fetch ? {page, offset[OFF_W-1:0]} : '0;
    assign busy      = (state != IDLE) || pend_valid;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            page     <= '0;
            len      <= '0;
            offset   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            done     <= 1'b0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (fetch) begin
                tx_data  <= rd_data;
                tx_valid <= 1'b1;
                offset   <= offset + LEN_W'(1);
`ifdef CHECKSUM_EN
                csum     <= csum ^ rd_data;
                tx_last  <= 1'b0;
`else
                tx_last  <= (offset + LEN_W'(1) == len);
`endif
            end else if (hshake) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        page   <= next_req.page;
                        len    <= next_req.len;
                        offset <= '0;
`ifdef CHECKSUM_EN
                        csum   <= '0;
`endif
                        if (next_req.len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: state <= SEND;
`ifdef CHECKSUM_EN
                SEND: begin
                    if (!more && can_fetch) begin
                        tx_data  <= csum;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b1;
                        state    <= CSUM;
                    end
                end
                CSUM: begin
                    if (hshake) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
`else
                SEND: begin
                    if (hshake && tx_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
